// File: rtl/core_wb_scoreboard_pkg.sv
// Shared types and constants for the writeback/scoreboard slice.
// Contents:
//   XLEN, REG_AW, NREGS - data width, register address width, register count
//   wb_req_t            - one pending register write (destination + data)
//   wb_src_e            - which source owns the register-file write port
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_BUF,
    WB_LU
  } wb_src_e;

endpackage

// File: rtl/core_wb_scoreboard_if.sv
// Long-unit result channel (valid/ready handshake).
// Signals:
//   lu_valid - result valid (long unit -> scoreboard)
//   lu_ready - result accepted when lu_valid && lu_ready (scoreboard -> long unit)
//   lu_rd    - destination register of the result
//   lu_data  - result data
// Modports: master = long unit side, slave = writeback scoreboard side.
interface core_wb_scoreboard_if;

  logic                       lu_valid;
  logic                       lu_ready;
  logic [core_pkg::REG_AW-1:0] lu_rd;
  logic [core_pkg::XLEN-1:0]   lu_data;

  modport master (output lu_valid, output lu_rd, output lu_data, input lu_ready);
  modport slave  (input lu_valid, input lu_rd, input lu_data, output lu_ready);

endinterface

// File: rtl/core_wb_scoreboard_hold_buf.sv
// Single-entry holding register for a long-unit result that was accepted
// but could not be committed in the same cycle.
// Ports:
//   clk, rst_sync_n - clock, synchronous active-low reset
//   load_i          - capture load_req_i at the posedge (only when empty)
//   drain_i         - release the held entry at the posedge
//   load_req_i      - result to capture
//   full_o          - entry is occupied
//   ready_o         - buffer can accept a result (0 while in reset)
//   req_o           - held entry
module wb_hold_buf
  import core_pkg::*;
(
  input  logic    clk,
  input  logic    rst_sync_n,
  input  logic    load_i,
  input  logic    drain_i,
  input  wb_req_t load_req_i,
  output logic    full_o,
  output logic    ready_o,
  output wb_req_t req_o
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;

  // load and drain are mutually exclusive: loading needs ready (empty),
  // draining needs full.
  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (load_i) begin
      full_d = 1'b1;
      req_d  = load_req_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  // Depends only on state and reset, never on lu_valid.
  assign ready_o = rst_sync_n && !full_q;
  assign full_o  = full_q;
  assign req_o   = req_q;

endmodule

// File: rtl/core_wb_scoreboard.sv
// Write-side companion of the register file. Merges ALU writebacks with
// long-unit results and tracks pending long-op destinations for hazard
// detection.
// Ports:
//   clk, rst_sync_n                  - clock, synchronous active-low reset
//   stall_n                          - 0 freezes commits and scoreboard updates
//   issue_valid/issue_long/issue_rd  - instruction issuing this cycle
//   rs1_addr, rs2_addr               - sources of the issuing instruction
//   rs1_busy, rs2_busy, rd_busy      - RAW/WAW hazard flags
//   alu_wb_valid/alu_wb_rd/alu_wb_data - ALU writeback, no backpressure
//   lu                               - long-unit result channel (slave)
//   reg_waddr/reg_wdata/reg_wen      - register file write port
//   sb_err                           - sticky: unexpected long result
module core_wb_scoreboard
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_sync_n,
  input  logic              stall_n,
  input  logic              issue_valid,
  input  logic              issue_long,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  core_wb_scoreboard_if.slave lu,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [XLEN-1:0]   reg_wdata,
  output logic              reg_wen,
  output logic              sb_err
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic             err_q, err_d;

  wb_src_e src;
  wb_req_t commit;
  wb_req_t lu_req;
  wb_req_t buf_req;
  logic    buf_full, buf_ready, buf_load, buf_drain;
  logic    lu_fire, long_commit;

  assign lu_req  = '{rd: lu.lu_rd, data: lu.lu_data};
  assign lu_fire = lu.lu_valid && buf_ready;
  assign lu.lu_ready = buf_ready;

  // Commit arbitration: ALU, then held result, then pass-through.
  always_comb begin
    src    = WB_NONE;
    commit = '0;
    if (rst_sync_n && stall_n) begin
      if (alu_wb_valid) begin
        src    = WB_ALU;
        commit = '{rd: alu_wb_rd, data: alu_wb_data};
      end else if (buf_full) begin
        src    = WB_BUF;
        commit = buf_req;
      end else if (lu_fire) begin
        src    = WB_LU;
        commit = lu_req;
      end
    end
  end

  assign long_commit = (src == WB_BUF) || (src == WB_LU);
  assign reg_wen     = (src != WB_NONE) && (commit.rd != '0);
  assign reg_waddr   = reg_wen ? commit.rd : '0;
  assign reg_wdata   = reg_wen ? commit.data : '0;

  // Accepted but not passed through (ALU won or stalled): park it.
  assign buf_load  = lu_fire && (src != WB_LU);
  assign buf_drain = (src == WB_BUF);

  wb_hold_buf u_hold (
    .clk        (clk),
    .rst_sync_n (rst_sync_n),
    .load_i     (buf_load),
    .drain_i    (buf_drain),
    .load_req_i (lu_req),
    .full_o     (buf_full),
    .ready_o    (buf_ready),
    .req_o      (buf_req)
  );

  // Clear before set so a same-cycle reissue keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    if (stall_n) begin
      if (long_commit && commit.rd != '0) pend_d[commit.rd] = 1'b0;
      if (issue_valid && issue_long && issue_rd != '0) pend_d[issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  assign err_d = err_q || (lu_fire && lu.lu_rd != '0 && !pend_q[lu.lu_rd]);

  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // The register file forwards a same-cycle long write, so that source is free.
  assign rs1_busy = rst_sync_n && rs1_addr != '0 && pend_q[rs1_addr] &&
                    !(reg_wen && long_commit && reg_waddr == rs1_addr);
  assign rs2_busy = rst_sync_n && rs2_addr != '0 && pend_q[rs2_addr] &&
                    !(reg_wen && long_commit && reg_waddr == rs2_addr);
  assign rd_busy  = rst_sync_n && issue_rd != '0 && pend_q[issue_rd];
  assign sb_err   = err_q;

endmodule

// File: tb/tb_core_wb_scoreboard.sv
module tb_core_wb_scoreboard;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_sync_n = 1'b0, stall_n = 1'b1;
  logic              issue_valid = 1'b0, issue_long = 1'b0;
  logic [REG_AW-1:0] issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic              rs1_busy, rs2_busy, rd_busy;
  logic              alu_wb_valid = 1'b0;
  logic [REG_AW-1:0] alu_wb_rd = '0;
  logic [XLEN-1:0]   alu_wb_data = '0;
  logic              lu_valid = 1'b0;
  logic [REG_AW-1:0] lu_rd = '0;
  logic [XLEN-1:0]   lu_data = '0;
  logic [REG_AW-1:0] reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
  logic              reg_wen, sb_err;

  core_wb_scoreboard_if lu_if ();
  assign lu_if.lu_valid = lu_valid;
  assign lu_if.lu_rd    = lu_rd;
  assign lu_if.lu_data  = lu_data;

  core_wb_scoreboard dut (
    .clk(clk), .rst_sync_n(rst_sync_n), .stall_n(stall_n),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lu(lu_if),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen), .sb_err(sb_err)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Reference model: pending set as a bit array, held results as a queue.
  bit      pend [NREGS];
  wb_req_t held [$];
  bit      err_m;

  bit                e_wen, e_long, e_acc, e_ready, e_rs1, e_rs2, e_rdb;
  logic [REG_AW-1:0] e_addr;
  logic [XLEN-1:0]   e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void predict();
    e_ready = rst_sync_n && held.size() == 0;
    e_acc   = lu_valid && e_ready;
    e_wen = 0; e_long = 0; e_addr = '0; e_data = '0;
    if (rst_sync_n && stall_n) begin
      if (alu_wb_valid) begin
        e_wen = alu_wb_rd != 0; e_addr = alu_wb_rd; e_data = alu_wb_data;
      end else if (held.size() > 0) begin
        e_long = 1; e_wen = held[0].rd != 0; e_addr = held[0].rd; e_data = held[0].data;
      end else if (e_acc) begin
        e_long = 1; e_wen = lu_rd != 0; e_addr = lu_rd; e_data = lu_data;
      end
    end
    e_rs1 = rst_sync_n && rs1_addr != 0 && pend[rs1_addr] && !(e_wen && e_long && e_addr == rs1_addr);
    e_rs2 = rst_sync_n && rs2_addr != 0 && pend[rs2_addr] && !(e_wen && e_long && e_addr == rs2_addr);
    e_rdb = rst_sync_n && issue_rd != 0 && pend[issue_rd];
  endfunction

  task automatic sample();
    #1;
    predict();
    chk("reg_wen", reg_wen, e_wen);
    if (e_wen) begin
      chk("reg_waddr", reg_waddr, e_addr);
      chk("reg_wdata", reg_wdata, e_data);
    end
    chk("lu_ready", lu_if.lu_ready, e_ready);
    chk("rs1_busy", rs1_busy, e_rs1);
    chk("rs2_busy", rs2_busy, e_rs2);
    chk("rd_busy", rd_busy, e_rdb);
    chk("sb_err", sb_err, err_m);
  endtask

  task automatic adv();
    if (!rst_sync_n) begin
      foreach (pend[i]) pend[i] = 0;
      held.delete();
      err_m = 0;
    end else begin
      if (e_acc && lu_rd != 0 && !pend[lu_rd]) err_m = 1;
      if (stall_n) begin
        if (e_long && e_addr != 0) pend[e_addr] = 0;
        if (!alu_wb_valid && held.size() > 0) void'(held.pop_front());
        if (issue_valid && issue_long && issue_rd != 0) pend[issue_rd] = 1;
      end
      if (e_acc && !e_long) held.push_back('{rd: lu_rd, data: lu_data});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst_sync_n = 1; stall_n = 1;
    issue_valid = 0; issue_long = 0; issue_rd = 0;
    rs1_addr = 0; rs2_addr = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd);
    idle(); issue_valid = 1; issue_long = 1; issue_rd = rd;
    sample(); adv();
  endtask

  initial begin
    bit acc_prev;
    int pl [$];
    err_m = 0;
    foreach (pend[i]) pend[i] = 0;

    // Reset with a long result offered
    rst_sync_n = 0; lu_valid = 1; lu_rd = 3; lu_data = 32'h1234;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_wen", reg_wen, 1'b0);
      chk("rst_ready", lu_if.lu_ready, 1'b0);
      adv();
    end
    idle();
    sample();
    chk("post_rst_ready", lu_if.lu_ready, 1'b1);
    chk("post_rst_err", sb_err, 1'b0);
    adv();

    // Pass-through
    issue(5);
    idle(); rs1_addr = 5;
    sample(); chk("pt_rs1_busy", rs1_busy, 1'b1); adv();
    lu_valid = 1; lu_rd = 5; lu_data = 32'hDEADBEEF;
    sample();
    chk("pt_wen", reg_wen, 1'b1);
    chk("pt_waddr", reg_waddr, 5);
    chk("pt_wdata", reg_wdata, 32'hDEADBEEF);
    chk("pt_rs1_fwd", rs1_busy, 1'b0);
    adv();
    lu_valid = 0;
    sample(); chk("pt_cleared", rs1_busy, 1'b0); adv();

    // Contention: ALU wins, long result parked
    issue(7);
    idle(); alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'h11;
    lu_valid = 1; lu_rd = 7; lu_data = 32'h22;
    sample(); chk("ct_alu_addr", reg_waddr, 3); chk("ct_alu_data", reg_wdata, 32'h11); adv();
    idle();
    sample();
    chk("ct_ready_full", lu_if.lu_ready, 1'b0);
    chk("ct_buf_addr", reg_waddr, 7);
    chk("ct_buf_data", reg_wdata, 32'h22);
    adv();
    sample(); chk("ct_ready_back", lu_if.lu_ready, 1'b1); adv();

    // Set/clear race on rd=9
    issue(9);
    idle(); lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
    issue_valid = 1; issue_long = 1; issue_rd = 9;
    sample(); adv();
    idle(); issue_rd = 9;
    sample(); chk("race_rd_busy", rd_busy, 1'b1); adv();
    idle(); lu_valid = 1; lu_rd = 9; lu_data = 32'h9A;
    sample(); adv();

    // x0 and error
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 0;
    sample(); chk("x0_rd_busy", rd_busy, 1'b0); adv();
    idle(); lu_valid = 1; lu_rd = 0; lu_data = 32'h77;
    sample(); chk("x0_ready", lu_if.lu_ready, 1'b1); chk("x0_wen", reg_wen, 1'b0); adv();
    idle();
    sample(); chk("x0_no_err", sb_err, 1'b0); adv();
    lu_valid = 1; lu_rd = 12; lu_data = 32'h5;
    sample(); chk("err_waddr", reg_waddr, 12); chk("err_wdata", reg_wdata, 32'h5); adv();
    idle();
    sample(); chk("err_set", sb_err, 1'b1); adv();
    sample(); chk("err_sticky", sb_err, 1'b1); adv();

    // Stall with a full buffer
    issue(4);
    idle(); alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 32'hAA;
    lu_valid = 1; lu_rd = 4; lu_data = 32'h44;
    sample(); adv();
    idle(); stall_n = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("st_wen", reg_wen, 1'b0);
      chk("st_ready", lu_if.lu_ready, 1'b0);
      adv();
    end
    stall_n = 1;
    sample(); chk("st_waddr", reg_waddr, 4); chk("st_wdata", reg_wdata, 32'h44); adv();
    sample(); chk("st_ready_back", lu_if.lu_ready, 1'b1); adv();

    // Randomized traffic against the model, with a mid-run reset
    acc_prev = 1;
    for (int c = 0; c < 500; c++) begin
      rst_sync_n  = !(c >= 250 && c < 252);
      stall_n     = $urandom_range(0, 7) != 0;
      issue_valid = $urandom_range(0, 1);
      issue_long  = $urandom_range(0, 1);
      issue_rd    = REG_AW'($urandom_range(0, 15));
      rs1_addr    = REG_AW'($urandom_range(0, 15));
      rs2_addr    = REG_AW'($urandom_range(0, 15));
      alu_wb_valid = $urandom_range(0, 2) == 0;
      alu_wb_rd    = 0;
      for (int t = 0; t < 32; t++) begin
        logic [REG_AW-1:0] r;
        r = REG_AW'($urandom_range(0, 15));
        if (!pend[r]) begin alu_wb_rd = r; break; end
      end
      alu_wb_data = $urandom;
      if (!lu_valid || acc_prev) begin
        pl.delete();
        for (int i = 1; i < NREGS; i++)
          if (pend[i] && !(held.size() > 0 && held[0].rd == i)) pl.push_back(i);
        lu_valid = $urandom_range(0, 1);
        if (pl.size() > 0 && $urandom_range(0, 9) != 0)
          lu_rd = REG_AW'(pl[$urandom_range(0, pl.size() - 1)]);
        else
          lu_rd = REG_AW'($urandom_range(0, 15));
        lu_data = $urandom;
      end
      sample();
      acc_prev = e_acc;
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/core_wb_scoreboard.md
Name: core_wb_scoreboard

Overview:
- Write-side companion of the core register file: sole producer of reg_waddr/reg_wdata/reg_wen.
- Merges single-cycle ALU writebacks with results from long-latency units (load, mul/div) over a valid/ready handshake.
- Keeps a pending-destination scoreboard so issue logic can stall on RAW and WAW hazards against in-flight long ops.
- Sits between the execute/long-unit outputs and the register file; busy flags feed the hazard unit.

Parameters:
XLEN, 32, data width of a register.
REG_AW, 5, register address width; register count is 2**REG_AW, and x0 is never tracked or written.

Ports:
clk  in  1  core clock.
rst_sync_n  in  1  reset, synchronous, active-low.
stall_n  in  1  pipeline advance; 0 freezes all commits and scoreboard updates.
issue_valid  in  1  instruction issuing this cycle.
issue_long  in  1  issuing instruction completes via the long-unit port.
issue_rd  in  REG_AW  destination of the issuing instruction.
rs1_addr, rs2_addr  in  REG_AW  source addresses of the issuing instruction.
rs1_busy, rs2_busy  out  1  source is pending and not being written this cycle.
rd_busy  out  1  issue_rd is pending (WAW); hazard unit stalls the issue.
alu_wb_valid  in  1  ALU writeback request, no backpressure.
alu_wb_rd  in  REG_AW  ALU destination.
alu_wb_data  in  XLEN  ALU result.
lu_valid  in  1  long-unit result valid.
lu_ready  out  1  long-unit result accepted when lu_valid && lu_ready.
lu_rd  in  REG_AW  long-unit destination.
lu_data  in  XLEN  long-unit result.
reg_waddr  out  REG_AW  register file write address.
reg_wdata  out  XLEN  register file write data.
reg_wen  out  1  register file write enable, committed this cycle.
sb_err  out  1  sticky: a long result arrived for a non-pending rd != 0.

Behaviour:
- Reset (rst_sync_n=0 at a posedge)
  - pending vector cleared, hold buffer emptied, sb_err=0.
  - While rst_sync_n=0: reg_wen=0, lu_ready=0, all busy outputs 0.
- Hold buffer: a single entry (rd, data, full).
- lu_ready is 1 whenever the hold buffer is empty, independent of lu_valid (no combinational path from lu_valid to lu_ready).
- Commit arbitration, combinational, in priority order, only when stall_n=1:
  1. alu_wb_valid: write ALU result.
  2. Hold buffer full: write buffer contents.
  3. lu_valid && lu_ready: pass-through, write lu data in the same cycle, with zero latency.
- A long result accepted but not committed this cycle (ALU won, or stall_n=0) is captured into the buffer at the posedge.
- Buffer full plus a new long result cannot occur, because lu_ready=0 while full.
- reg_wen=1 only for a commit with rd != 0. rd=0 results are consumed (handshake completes, buffer drains) with reg_wen=0.
- reg_waddr/reg_wdata reflect the selected source when reg_wen=1; they are don't-care otherwise (implementation drives 0).
- Scoreboard, updated at the posedge when stall_n=1:
  - Set pending[issue_rd] when issue_valid && issue_long && issue_rd != 0.
  - Clear pending[rd] when a long-result commit (buffer or pass-through) writes rd.
  - Set and clear of the same rd in one cycle: set wins (a new op owns the register).
- Busy outputs:
  - rsN_busy = rsN != 0 && pending[rsN] && !(reg_wen && long commit && reg_waddr == rsN). The register file forwards the same-cycle write.
  - rd_busy = issue_rd != 0 && pending[issue_rd].
- ALU writes never touch the scoreboard. The hazard unit guarantees no ALU write targets a pending rd.
- sb_err is set when a long result is accepted with lu_rd != 0 and pending[lu_rd]=0. The result is still committed. Cleared only by reset.
- stall_n=0: no commit, no scoreboard change, buffer held. A long result may still be accepted into the empty buffer.
- Reset mid-operation discards buffered results and pending state.

Decomposition:
- Package core_pkg: XLEN, REG_AW constants; typedef wb_req_t {rd, data}; typedef wb_src_e {WB_NONE, WB_ALU, WB_BUF, WB_LU}.
- One sub-module, wb_hold_buf: single-entry holding register with full flag, load/drain strobes, and the ready output.

Test Plan:
- Reset: hold rst_sync_n=0 for 3 cycles with lu_valid=1 → reg_wen=0, lu_ready=0; after release, lu_ready=1, rs1_busy=0, sb_err=0.
- Pass-through: issue long rd=5, then rs1_addr=5 → rs1_busy=1. Then lu_valid rd=5 data 0xDEADBEEF with no ALU → same cycle reg_wen=1, waddr=5, wdata=0xDEADBEEF, rs1_busy=0; next cycle pending[5]=0.
- Contention: pending[7]=1. Same cycle alu rd=3 data 0x11 and lu rd=7 data 0x22 → ALU written, lu buffered; next cycle lu_ready=0 and rd=7/0x22 written; following cycle lu_ready=1.
- Set/clear race: pending[9]=1. Long result rd=9 commits while issue long rd=9 → pending[9] remains 1, rd_busy=1 for issue_rd=9.
- x0 and error: issue long rd=0 → rd_busy=0, no pending. lu rd=0 → handshake completes, reg_wen=0. lu rd=12 not pending, data 0x5 → written, sb_err=1 and stays 1.
- Stall: buffer full (rd=4), stall_n=0 for 2 cycles → reg_wen=0, buffer held, lu_ready=0; stall_n=1 → rd=4 written.
